lcd_fbarb: RTL and testbench

LCD_FBARB -- requirements
Module: lcd_fbarb

---
 rtl/lcd_fbarb.sv | 166 ++++++++++++++++
 tb/tb_lcd_fbarb.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_fbarb.sv
// lcd_fbarb: arbitrates a single asynchronous SRAM frame buffer between a
// write requester (STN timing detector) and a read requester (TFT timing
// generator). Each access is a fixed-shape strobe sequence whose wait phase
// is WAIT_CYC clocks long. Contention alternates between the two sides.
//
// Ports
//   clk, rst_x                  clock, asynchronous active-low reset
//   fifo_wrreq/wrack/waddr/wdata  write request (held until wrack pulse)
//   fifo_rdreq/rdack/raddr/rdata  read request (held until rdack pulse);
//                                 fifo_rdata valid with rdack and held after
//   sram_cs_x/we_x/oe_x         active-low SRAM strobes
//   sram_addr, sram_dout        registered SRAM address / write data
//   sram_doe                    high while sram_dout drives the data bus
//   sram_din                    SRAM read data
//   addr_err                    sticky: a request addressed beyond FB_LAST
module lcd_fbarb #(
    parameter int unsigned WAIT_CYC = 2,
    parameter logic [12:0] FB_LAST  = 13'h12bf
) (
    input  logic        clk,
    input  logic        rst_x,
    input  logic        fifo_wrreq,
    output logic        fifo_wrack,
    input  logic [12:0] fifo_waddr,
    input  logic [7:0]  fifo_wdata,
    input  logic        fifo_rdreq,
    output logic        fifo_rdack,
    input  logic [12:0] fifo_raddr,
    output logic [7:0]  fifo_rdata,
    output logic        sram_cs_x,
    output logic        sram_we_x,
    output logic        sram_oe_x,
    output logic [12:0] sram_addr,
    output logic [7:0]  sram_dout,
    output logic        sram_doe,
    input  logic [7:0]  sram_din,
    output logic        addr_err
);

    localparam logic [2:0] CNT_INIT = 3'(WAIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_RD_ADDR,
        S_RD_WAIT,
        S_RD_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_cnt;
    logic       r_last_rd;
    logic       r_bad;
    logic       w_grant_wr;
    logic       w_grant_rd;
    logic       w_wr_bad;
    logic       w_rd_bad;

    assign w_wr_bad = (fifo_waddr > FB_LAST);
    assign w_rd_bad = (fifo_raddr > FB_LAST);

    // Next state and arbitration
    always_comb begin
        w_next     = r_state;
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fifo_wrreq && fifo_rdreq) begin
                    // Serve whichever side did not win last time.
                    w_grant_wr = r_last_rd;
                    w_grant_rd = ~r_last_rd;
                end else begin
                    w_grant_wr = fifo_wrreq;
                    w_grant_rd = fifo_rdreq;
                end
                if (w_grant_wr)
                    w_next = S_WR_SETUP;
                else if (w_grant_rd)
                    w_next = S_RD_ADDR;
            end
            S_WR_SETUP: w_next = S_WR_PULSE;
            S_WR_PULSE: if (r_cnt == 3'd0) w_next = S_WR_HOLD;
            S_WR_HOLD:  w_next = S_IDLE;
            S_RD_ADDR:  w_next = S_RD_WAIT;
            S_RD_WAIT:  if (r_cnt == 3'd0) w_next = S_RD_DONE;
            S_RD_DONE:  w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Strobes decoded from the state register; an out-of-range write keeps
    // chip select high so the SRAM ignores the otherwise normal sequence.
    always_comb begin
        sram_cs_x  = 1'b1;
        sram_we_x  = 1'b1;
        sram_oe_x  = 1'b1;
        sram_doe   = 1'b0;
        fifo_wrack = 1'b0;
        fifo_rdack = 1'b0;
        case (r_state)
            S_WR_SETUP: begin
                sram_cs_x = r_bad;
                sram_doe  = 1'b1;
            end
            S_WR_PULSE: begin
                sram_cs_x = r_bad;
                sram_we_x = 1'b0;
                sram_doe  = 1'b1;
            end
            S_WR_HOLD: begin
                sram_cs_x  = r_bad;
                sram_doe   = 1'b1;
                fifo_wrack = 1'b1;
            end
            S_RD_ADDR, S_RD_WAIT: begin
                sram_cs_x = 1'b0;
                sram_oe_x = 1'b0;
            end
            S_RD_DONE: fifo_rdack = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_last_rd  <= 1'b1;
            r_bad      <= 1'b0;
            sram_addr  <= '0;
            sram_dout  <= '0;
            fifo_rdata <= '0;
            addr_err   <= 1'b0;
        end else begin
            r_state <= w_next;

            if (r_state == S_WR_SETUP || r_state == S_RD_ADDR)
                r_cnt <= CNT_INIT;
            else if ((r_state == S_WR_PULSE || r_state == S_RD_WAIT) && r_cnt != 3'd0)
                r_cnt <= r_cnt - 3'd1;

            if (w_grant_wr) begin
                sram_addr <= fifo_waddr;
                sram_dout <= fifo_wdata;
                r_bad     <= w_wr_bad;
                r_last_rd <= 1'b0;
                if (w_wr_bad)
                    addr_err <= 1'b1;
            end else if (w_grant_rd) begin
                sram_addr <= fifo_raddr;
                r_bad     <= w_rd_bad;
                r_last_rd <= 1'b1;
                if (w_rd_bad)
                    addr_err <= 1'b1;
            end

            if (r_state == S_RD_WAIT && r_cnt == 3'd0)
                fifo_rdata <= r_bad ? 8'h00 : sram_din;
        end
    end

endmodule

// File: tb/tb_lcd_fbarb.sv
module tb_lcd_fbarb;

    logic        clk = 1'b0;
    logic        rst_x = 1'b0;
    logic        wrreq = 1'b0;
    logic [12:0] waddr = '0;
    logic [7:0]  wdata = '0;
    logic        rdreq = 1'b0;
    logic [12:0] raddr = '0;
    logic [7:0]  din = '0;

    logic        wrack2, rdack2, cs2, we2, oe2, doe2, err2;
    logic [7:0]  rdata2, dout2;
    logic [12:0] addr2;
    logic        wrack1, rdack1, cs1, we1, oe1, doe1, err1;
    logic [7:0]  rdata1, dout1;
    logic [12:0] addr1;
    logic        wrack7, rdack7, cs7, we7, oe7, doe7, err7;
    logic [7:0]  rdata7, dout7;
    logic [12:0] addr7;

    int n_vec = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lcd_fbarb #(.WAIT_CYC(2), .FB_LAST(13'h12bf)) u_w2 (
        .clk(clk), .rst_x(rst_x),
        .fifo_wrreq(wrreq), .fifo_wrack(wrack2), .fifo_waddr(waddr), .fifo_wdata(wdata),
        .fifo_rdreq(rdreq), .fifo_rdack(rdack2), .fifo_raddr(raddr), .fifo_rdata(rdata2),
        .sram_cs_x(cs2), .sram_we_x(we2), .sram_oe_x(oe2), .sram_addr(addr2),
        .sram_dout(dout2), .sram_doe(doe2), .sram_din(din), .addr_err(err2)
    );

    lcd_fbarb #(.WAIT_CYC(1), .FB_LAST(13'h12bf)) u_w1 (
        .clk(clk), .rst_x(rst_x),
        .fifo_wrreq(wrreq), .fifo_wrack(wrack1), .fifo_waddr(waddr), .fifo_wdata(wdata),
        .fifo_rdreq(rdreq), .fifo_rdack(rdack1), .fifo_raddr(raddr), .fifo_rdata(rdata1),
        .sram_cs_x(cs1), .sram_we_x(we1), .sram_oe_x(oe1), .sram_addr(addr1),
        .sram_dout(dout1), .sram_doe(doe1), .sram_din(din), .addr_err(err1)
    );

    lcd_fbarb #(.WAIT_CYC(7), .FB_LAST(13'h12bf)) u_w7 (
        .clk(clk), .rst_x(rst_x),
        .fifo_wrreq(wrreq), .fifo_wrack(wrack7), .fifo_waddr(waddr), .fifo_wdata(wdata),
        .fifo_rdreq(rdreq), .fifo_rdack(rdack7), .fifo_raddr(raddr), .fifo_rdata(rdata7),
        .sram_cs_x(cs7), .sram_we_x(we7), .sram_oe_x(oe7), .sram_addr(addr7),
        .sram_dout(dout7), .sram_doe(doe7), .sram_din(din), .addr_err(err7)
    );

    // Leaves the bench 1 time unit after a rising edge with reset released.
    task automatic do_reset();
        @(posedge clk); #1;
        wrreq = 1'b0;
        rdreq = 1'b0;
        rst_x = 1'b0;
        @(posedge clk); #1;
        rst_x = 1'b1;
    endtask

    task automatic test_reset();
        logic [35:0] got;
        rst_x = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got = {cs2, we2, oe2, doe2, wrack2, rdack2, addr2, dout2, rdata2, err2};
        n_vec++;
        if (got !== {6'b111000, 13'h0, 8'h0, 8'h0, 1'b0}) begin
            $display("FAIL reset_vals got=%h exp=%h", got, {6'b111000, 13'h0, 8'h0, 8'h0, 1'b0});
            n_fail++;
        end
        rst_x = 1'b1;
        @(posedge clk); #1;
        got = {cs2, we2, oe2, doe2, wrack2, rdack2, addr2, dout2, rdata2, err2};
        n_vec++;
        if (got !== {6'b111000, 13'h0, 8'h0, 8'h0, 1'b0}) begin
            $display("FAIL reset_idle got=%h exp=%h", got, {6'b111000, 13'h0, 8'h0, 8'h0, 1'b0});
            n_fail++;
        end
    endtask

    task automatic test_write();
        logic [5:0] exp_ctl;
        waddr = 13'h0028;
        wdata = 8'hA5;
        wrreq = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            exp_ctl = {1'b0, (c == 2 || c == 3) ? 1'b0 : 1'b1, 1'b1, 1'b1, (c == 4), 1'b0};
            n_vec++;
            if ({cs2, we2, oe2, doe2, wrack2, rdack2} !== exp_ctl) begin
                $display("FAIL write_ctl c=%0d got=%b exp=%b", c, {cs2, we2, oe2, doe2, wrack2, rdack2}, exp_ctl);
                n_fail++;
            end
            if (c == 1) begin
                waddr = 13'h0000;
                wdata = 8'h00;
            end
            if (c == 4) begin
                n_vec++;
                if ({addr2, dout2} !== {13'h0028, 8'hA5}) begin
                    $display("FAIL write_addr_data got=%h/%h exp=0028/a5", addr2, dout2);
                    n_fail++;
                end
                wrreq = 1'b0;
            end
        end
        @(posedge clk); #1;
        n_vec++;
        if ({cs2, we2, oe2, doe2, wrack2, rdack2} !== 6'b111000) begin
            $display("FAIL write_idle got=%b exp=111000", {cs2, we2, oe2, doe2, wrack2, rdack2});
            n_fail++;
        end
    endtask

    task automatic test_read();
        logic [5:0] exp_ctl;
        raddr = 13'h12bf;
        din   = 8'h3C;
        rdreq = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            exp_ctl = {(c == 4), 1'b1, (c == 4), 1'b0, 1'b0, (c == 4)};
            n_vec++;
            if ({cs2, we2, oe2, doe2, wrack2, rdack2} !== exp_ctl) begin
                $display("FAIL read_ctl c=%0d got=%b exp=%b", c, {cs2, we2, oe2, doe2, wrack2, rdack2}, exp_ctl);
                n_fail++;
            end
            if (c == 1) begin
                n_vec++;
                if (addr2 !== 13'h12bf) begin
                    $display("FAIL read_addr got=%h exp=12bf", addr2);
                    n_fail++;
                end
            end
            if (c == 3) begin
                n_vec++;
                if (rdata2 !== 8'h00) begin
                    $display("FAIL read_early got=%h exp=00", rdata2);
                    n_fail++;
                end
            end
            if (c == 4) begin
                n_vec++;
                if ({rdata2, err2} !== {8'h3C, 1'b0}) begin
                    $display("FAIL read_data got=%h err=%b exp=3c err=0", rdata2, err2);
                    n_fail++;
                end
                rdreq = 1'b0;
                din   = 8'hFF;
            end
        end
        @(posedge clk); #1;
        n_vec++;
        if ({rdata2, rdack2, cs2} !== {8'h3C, 1'b0, 1'b1}) begin
            $display("FAIL read_hold got=%h rdack=%b cs=%b exp=3c 0 1", rdata2, rdack2, cs2);
            n_fail++;
        end
    endtask

    task automatic test_contention();
        int k = 0;
        do_reset();
        waddr = 13'h0100;
        wdata = 8'h55;
        raddr = 13'h0200;
        din   = 8'h99;
        wrreq = 1'b1;
        rdreq = 1'b1;
        for (int c = 1; c <= 40 && k < 4; c++) begin
            @(posedge clk); #1;
            n_vec++;
            if ((wrack2 && rdack2) || (!we2 && !oe2)) begin
                $display("FAIL contention_excl c=%0d wrack=%b rdack=%b we=%b oe=%b exp no overlap", c, wrack2, rdack2, we2, oe2);
                n_fail++;
            end
            if (wrack2 || rdack2) begin
                n_vec++;
                if ({wrack2, rdack2, c} !== {(k % 2 == 0), (k % 2 == 1), 4 + 5 * k}) begin
                    $display("FAIL contention_order k=%0d got wr=%b rd=%b cyc=%0d exp wr=%0d cyc=%0d",
                             k, wrack2, rdack2, c, (k % 2 == 0), 4 + 5 * k);
                    n_fail++;
                end
                if (rdack2) begin
                    n_vec++;
                    if (rdata2 !== 8'h99) begin
                        $display("FAIL contention_rdata got=%h exp=99", rdata2);
                        n_fail++;
                    end
                end
                k++;
                if (k == 4) begin
                    wrreq = 1'b0;
                    rdreq = 1'b0;
                end
            end
        end
        n_vec++;
        if (k != 4) begin
            $display("FAIL contention_timeout acks=%0d exp=4", k);
            n_fail++;
        end
        wrreq = 1'b0;
        rdreq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_addr_err();
        logic [5:0] exp_ctl;
        waddr = 13'h12c0;
        wdata = 8'hEE;
        wrreq = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            exp_ctl = {1'b1, (c == 2 || c == 3) ? 1'b0 : 1'b1, 1'b1, 1'b1, (c == 4), 1'b0};
            n_vec++;
            if ({cs2, we2, oe2, doe2, wrack2, rdack2, err2} !== {exp_ctl, 1'b1}) begin
                $display("FAIL bad_write c=%0d got=%b exp=%b", c, {cs2, we2, oe2, doe2, wrack2, rdack2, err2}, {exp_ctl, 1'b1});
                n_fail++;
            end
            if (c == 4) wrreq = 1'b0;
        end
        @(posedge clk); #1;
        waddr = 13'h0010;
        wdata = 8'h3A;
        wrreq = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (c == 1 || c == 4) begin
                n_vec++;
                if ({cs2, wrack2, err2} !== {1'b0, (c == 4), 1'b1}) begin
                    $display("FAIL err_sticky_wr c=%0d got=%b exp=%b", c, {cs2, wrack2, err2}, {1'b0, (c == 4), 1'b1});
                    n_fail++;
                end
            end
            if (c == 4) wrreq = 1'b0;
        end
        @(posedge clk); #1;
        raddr = 13'h1fff;
        din   = 8'h77;
        rdreq = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (c == 4) begin
                n_vec++;
                if ({rdack2, rdata2, err2} !== {1'b1, 8'h00, 1'b1}) begin
                    $display("FAIL bad_read got=%b/%h/%b exp=1/00/1", rdack2, rdata2, err2);
                    n_fail++;
                end
                rdreq = 1'b0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [5:0] exp_ctl;
        do_reset();
        waddr = 13'h0005;
        wdata = 8'h11;
        wrreq = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_vec++;
        if ({cs2, we2} !== 2'b00) begin
            $display("FAIL mid_pulse got cs/we=%b exp=00", {cs2, we2});
            n_fail++;
        end
        #2;
        rst_x = 1'b0;
        #1;
        n_vec++;
        if ({cs2, we2, doe2, wrack2} !== 4'b1100) begin
            $display("FAIL mid_async got=%b exp=1100", {cs2, we2, doe2, wrack2});
            n_fail++;
        end
        repeat (2) begin
            @(posedge clk); #1;
            n_vec++;
            if ({cs2, wrack2} !== 2'b10) begin
                $display("FAIL mid_held got cs/wrack=%b exp=10", {cs2, wrack2});
                n_fail++;
            end
        end
        rst_x = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            exp_ctl = {1'b0, (c == 2 || c == 3) ? 1'b0 : 1'b1, 1'b1, 1'b1, (c == 4), 1'b0};
            n_vec++;
            if ({cs2, we2, oe2, doe2, wrack2, rdack2} !== exp_ctl) begin
                $display("FAIL mid_rerun c=%0d got=%b exp=%b", c, {cs2, we2, oe2, doe2, wrack2, rdack2}, exp_ctl);
                n_fail++;
            end
            if (c == 1) begin
                n_vec++;
                if ({addr2, dout2} !== {13'h0005, 8'h11}) begin
                    $display("FAIL mid_addr got=%h/%h exp=0005/11", addr2, dout2);
                    n_fail++;
                end
            end
            if (c == 4) wrreq = 1'b0;
        end
    endtask

    task automatic test_wait_params();
        int a1 = 0, a7 = 0, n1 = 0, n7 = 0;
        do_reset();
        waddr = 13'h0033;
        wdata = 8'h44;
        wrreq = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 1) wrreq = 1'b0;
            if (wrack1 && a1 == 0) a1 = c;
            if (wrack7 && a7 == 0) a7 = c;
            if (!cs1) n1++;
            if (!cs7) n7++;
        end
        n_vec++;
        if ({a1, n1} !== {32'd3, 32'd3}) begin
            $display("FAIL wait1_write ack_cyc=%0d cs_low=%0d exp 3 3", a1, n1);
            n_fail++;
        end
        n_vec++;
        if ({a7, n7} !== {32'd9, 32'd9}) begin
            $display("FAIL wait7_write ack_cyc=%0d cs_low=%0d exp 9 9", a7, n7);
            n_fail++;
        end
        a1 = 0;
        a7 = 0;
        raddr = 13'h0040;
        din   = 8'h5A;
        rdreq = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 1) rdreq = 1'b0;
            if (rdack1 && a1 == 0) a1 = c;
            if (rdack7 && a7 == 0) a7 = c;
        end
        n_vec++;
        if ({a1, rdata1} !== {32'd3, 8'h5A}) begin
            $display("FAIL wait1_read ack_cyc=%0d data=%h exp 3 5a", a1, rdata1);
            n_fail++;
        end
        n_vec++;
        if ({a7, rdata7} !== {32'd9, 8'h5A}) begin
            $display("FAIL wait7_read ack_cyc=%0d data=%h exp 9 5a", a7, rdata7);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_addr_err();
        test_reset_mid();
        test_wait_params();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
